// File: rtl/snake_pkg.sv
// Shared types and constants for the snake game core.
// Playfield cells are indexed row*10 + col.
package snake_pkg;

  localparam int GRID_BITS = 101;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_LEFT  = 2'd3;

  localparam logic [4:0] ROW_MIN = 5'd1;
  localparam logic [4:0] ROW_MAX = 5'd8;
  localparam logic [3:0] COL_MIN = 4'd1;
  localparam logic [3:0] COL_MAX = 4'd9;

  localparam logic [GRID_BITS-1:0] GRID_ONE = GRID_BITS'(1);

  typedef enum logic [2:0] {
    S_INIT,
    S_RUN,
    S_CALC,
    S_UPDATE,
    S_REBUILD,
    S_DEAD
  } state_t;

endpackage

// File: rtl/cell_decoder.sv
// Splits a cell index into row/col and a one-hot grid bit.
// Indices above 100 decode to an empty grid.
module cell_decoder
  import snake_pkg::*;
(
  input  logic [7:0]           idx,
  output logic [4:0]           row,
  output logic [3:0]           col,
  output logic [GRID_BITS-1:0] onehot
);

  // pure combinational decode
  always_comb begin
    row    = 5'(idx / 8'd10);
    col    = 4'(idx % 8'd10);
    onehot = (idx <= 8'd100) ? (GRID_ONE << idx) : '0;
  end

endmodule

// File: rtl/snake_engine.sv
// Snake movement, collision and occupancy-grid core.
// One cell per step strobe; grids rebuilt after each move.
module snake_engine
  import snake_pkg::*;
#(
  parameter int MAX_LEN   = 16,
  parameter int INIT_LEN  = 3,
  parameter int INIT_HEAD = 45
) (
  input  logic                 clk_25M,
  input  logic                 rst,
  input  logic                 step,
  input  logic [1:0]           dir_in,
  input  logic [7:0]           apple_pos,
  input  logic [7:0]           barrier_pos,
  output logic [GRID_BITS-1:0] head_grid,
  output logic [GRID_BITS-1:0] body_grid,
  output logic [GRID_BITS-1:0] apple_grid,
  output logic [GRID_BITS-1:0] barrier_grid,
  output logic                 new_rnd,
  output logic                 game_over,
  output logic [4:0]           length,
  output logic [7:0]           score
);

  state_t state, state_nx;

  logic [1:0] dir;
  logic [7:0] pos [MAX_LEN];
  logic [7:0] nxt [MAX_LEN];
  logic [7:0] src [MAX_LEN];
  logic [4:0] len, nxt_len, src_len;

  logic [7:0] next_cell, next_q;
  logic       eat, eat_q;
  logic       wall, bar_hit, self_hit, hit;

  logic [4:0]           h_row, a_row, b_row;
  logic [3:0]           h_col, a_col, b_col;
  logic [GRID_BITS-1:0] h_oh, a_oh, b_oh, body_c;

  logic unused_rc;
  assign unused_rc = ^{a_row, a_col, b_row, b_col};

  assign length = len;

  function automatic logic [GRID_BITS-1:0] init_body();
    logic [GRID_BITS-1:0] b = '0;
    for (int i = 1; i < INIT_LEN; i++)
      b = b | (GRID_ONE << (INIT_HEAD - i));
    return b;
  endfunction

  cell_decoder u_apple (
    .idx    (apple_pos),
    .row    (a_row),
    .col    (a_col),
    .onehot (a_oh)
  );

  cell_decoder u_barrier (
    .idx    (barrier_pos),
    .row    (b_row),
    .col    (b_col),
    .onehot (b_oh)
  );

  // head cell: row/col for wall test in CALC,
  // one-hot of the (post-move) head for the grid load
  cell_decoder u_head (
    .idx    (src[0]),
    .row    (h_row),
    .col    (h_col),
    .onehot (h_oh)
  );

  // next head, wall and collision terms from the current head
  always_comb begin
    wall      = 1'b0;
    next_cell = pos[0];
    unique case (dir)
      DIR_UP: begin
        wall      = (h_row == ROW_MIN);
        next_cell = pos[0] - 8'd10;
      end
      DIR_RIGHT: begin
        wall      = (h_col == COL_MAX);
        next_cell = pos[0] + 8'd1;
      end
      DIR_DOWN: begin
        wall      = (h_row == ROW_MAX);
        next_cell = pos[0] + 8'd10;
      end
      DIR_LEFT: begin
        wall      = (h_col == COL_MIN);
        next_cell = pos[0] - 8'd1;
      end
      default: ;
    endcase
    eat      = (next_cell == apple_pos);
    bar_hit  = (next_cell == barrier_pos);
    self_hit = 1'b0;
    for (int i = 1; i < MAX_LEN; i++) begin
      if (5'(i) < len && pos[i] == next_cell &&
          !(5'(i) == len - 5'd1 && !eat))
        self_hit = 1'b1;
    end
    hit = wall | bar_hit | self_hit;
  end

  // shifted array and length as they stand after UPDATE
  always_comb begin
    nxt[0] = next_q;
    for (int i = 1; i < MAX_LEN; i++)
      nxt[i] = pos[i-1];
    nxt_len = (eat_q && len < 5'(MAX_LEN)) ? len + 5'd1 : len;
  end

  // grid source: the post-move array while in UPDATE
  always_comb begin
    for (int i = 0; i < MAX_LEN; i++)
      src[i] = (state == S_UPDATE) ? nxt[i] : pos[i];
    src_len = (state == S_UPDATE) ? nxt_len : len;
    body_c  = '0;
    for (int i = 1; i < MAX_LEN; i++) begin
      if (5'(i) < src_len)
        body_c = body_c | (GRID_ONE << src[i]);
    end
  end

  // state register
  always_ff @(posedge clk_25M) begin
    if (rst) state <= S_INIT;
    else     state <= state_nx;
  end

  // next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      S_INIT:    state_nx = S_RUN;
      S_RUN:     if (step) state_nx = S_CALC;
      S_CALC:    state_nx = hit ? S_DEAD : S_UPDATE;
      S_UPDATE:  state_nx = S_REBUILD;
      S_REBUILD: state_nx = S_RUN;
      S_DEAD:    state_nx = S_DEAD;
      default:   state_nx = S_INIT;
    endcase
  end

  // snake datapath: direction, positions, counters, grids
  always_ff @(posedge clk_25M) begin
    if (rst) begin
      dir       <= DIR_RIGHT;
      len       <= 5'(INIT_LEN);
      score     <= 8'd0;
      new_rnd   <= 1'b0;
      game_over <= 1'b0;
      next_q    <= 8'd0;
      eat_q     <= 1'b0;
      for (int i = 0; i < MAX_LEN; i++)
        pos[i] <= (i < INIT_LEN) ? 8'(INIT_HEAD - i) : 8'd0;
      head_grid <= GRID_ONE << INIT_HEAD;
      body_grid <= init_body();
    end else begin
      new_rnd <= 1'b0;
      unique case (state)
        S_RUN: begin
          if (step && dir_in != (dir ^ 2'd2))
            dir <= dir_in;
        end
        S_CALC: begin
          next_q <= next_cell;
          eat_q  <= eat;
          if (hit) game_over <= 1'b1;
          else     new_rnd   <= eat;
        end
        S_UPDATE: begin
          for (int i = 0; i < MAX_LEN; i++)
            pos[i] <= nxt[i];
          len <= nxt_len;
          if (eat_q) score <= score + 8'd1;
          head_grid <= h_oh;
          body_grid <= body_c;
        end
        S_REBUILD: begin
          head_grid <= h_oh;
          body_grid <= body_c;
        end
        default: ;
      endcase
    end
  end

  // apple/barrier grids follow the inputs every cycle
  always_ff @(posedge clk_25M) begin
    apple_grid   <= a_oh;
    barrier_grid <= b_oh;
  end

endmodule

// File: tb/tb_snake_engine.sv
// Directed bench for snake_engine.
// Inputs driven on negedge, outputs sampled on negedge.
module tb_snake_engine;

  logic         clk_25M = 1'b0;
  logic         rst;
  logic         step;
  logic [1:0]   dir_in;
  logic [7:0]   apple_pos;
  logic [7:0]   barrier_pos;
  logic [100:0] head_grid, body_grid, apple_grid, barrier_grid;
  logic         new_rnd, game_over;
  logic [4:0]   length;
  logic [7:0]   score;

  int n_chk  = 0;
  int n_pass = 0;

  snake_engine dut (
    .clk_25M      (clk_25M),
    .rst          (rst),
    .step         (step),
    .dir_in       (dir_in),
    .apple_pos    (apple_pos),
    .barrier_pos  (barrier_pos),
    .head_grid    (head_grid),
    .body_grid    (body_grid),
    .apple_grid   (apple_grid),
    .barrier_grid (barrier_grid),
    .new_rnd      (new_rnd),
    .game_over    (game_over),
    .length       (length),
    .score        (score)
  );

  always #20 clk_25M = ~clk_25M;

  function automatic logic [100:0] g(input int c);
    return 101'(1) << c;
  endfunction

  task automatic chk(input string tag,
                     input logic [100:0] got,
                     input logic [100:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic do_reset();
    @(negedge clk_25M);
    rst = 1'b1;
    repeat (2) @(negedge clk_25M);
    rst = 1'b0;
    @(negedge clk_25M);
  endtask

  // step at negedge t0; samples at t1..t3, returns at t4 (RUN)
  task automatic do_step(input  logic [1:0]   d,
                         output logic         r1,
                         output logic         r2,
                         output logic         r3,
                         output logic         go1,
                         output logic         go2,
                         output logic [100:0] h3);
    dir_in = d;
    step   = 1'b1;
    @(negedge clk_25M);
    step = 1'b0;
    r1   = new_rnd;
    go1  = game_over;
    @(negedge clk_25M);
    r2  = new_rnd;
    go2 = game_over;
    @(negedge clk_25M);
    r3 = new_rnd;
    h3 = head_grid;
    @(negedge clk_25M);
  endtask

  logic         r1, r2, r3, go1, go2;
  logic [100:0] h3;
  int           cells [15] = '{46, 47, 48, 49, 59, 69, 79, 89,
                               88, 87, 86, 85, 84, 83, 82};
  logic [1:0]   dirs  [15] = '{2'd1, 2'd1, 2'd1, 2'd1,
                               2'd2, 2'd2, 2'd2, 2'd2,
                               2'd3, 2'd3, 2'd3, 2'd3,
                               2'd3, 2'd3, 2'd3};

  initial begin
    rst         = 1'b1;
    step        = 1'b0;
    dir_in      = 2'd1;
    apple_pos   = 8'd46;
    barrier_pos = 8'd200;

    // reset release
    do_reset();
    chk("rst_head", head_grid, g(45));
    chk("rst_body", body_grid, g(44) | g(43));
    chk("rst_len", 101'(length), 101'(3));
    chk("rst_score", 101'(score), 101'(0));
    chk("rst_go", 101'(game_over), 101'(0));
    chk("rst_rnd", 101'(new_rnd), 101'(0));
    chk("apple_grid", apple_grid, g(46));
    chk("barrier_off", barrier_grid, 101'(0));

    // eat to the right
    do_step(2'd1, r1, r2, r3, go1, go2, h3);
    chk("eat_rnd_n1", 101'(r1), 101'(0));
    chk("eat_rnd_n2", 101'(r2), 101'(1));
    chk("eat_rnd_n3", 101'(r3), 101'(0));
    chk("eat_head", h3, g(46));
    chk("eat_body", body_grid, g(45) | g(44) | g(43));
    chk("eat_len", 101'(length), 101'(4));
    chk("eat_score", 101'(score), 101'(1));

    // reversal requests are ignored
    apple_pos = 8'd0;
    do_reset();
    do_step(2'd3, r1, r2, r3, go1, go2, h3);
    chk("rev_head1", head_grid, g(46));
    do_step(2'd3, r1, r2, r3, go1, go2, h3);
    chk("rev_head2", head_grid, g(47));
    chk("rev_go", 101'(game_over), 101'(0));

    // wall at col 9, apple beyond the wall
    do_step(2'd1, r1, r2, r3, go1, go2, h3);
    do_step(2'd1, r1, r2, r3, go1, go2, h3);
    chk("wall_pre", head_grid, g(49));
    apple_pos = 8'd50;
    do_step(2'd1, r1, r2, r3, go1, go2, h3);
    chk("wall_go_n1", 101'(go1), 101'(0));
    chk("wall_go_n2", 101'(go2), 101'(1));
    chk("wall_no_rnd", 101'(r2), 101'(0));
    chk("wall_score", 101'(score), 101'(0));
    chk("wall_frozen", head_grid, g(49));
    do_step(2'd2, r1, r2, r3, go1, go2, h3);
    chk("dead_head", head_grid, g(49));
    chk("dead_body", body_grid, g(48) | g(47));
    chk("dead_go", 101'(game_over), 101'(1));
    apple_pos = 8'd0;
    do_reset();
    chk("rerst_head", head_grid, g(45));
    chk("rerst_go", 101'(game_over), 101'(0));
    chk("rerst_len", 101'(length), 101'(3));

    // barrier straight below
    barrier_pos = 8'd55;
    do_reset();
    chk("barrier_grid", barrier_grid, g(55));
    do_step(2'd2, r1, r2, r3, go1, go2, h3);
    chk("barrier_go", 101'(go2), 101'(1));
    chk("barrier_head", head_grid, g(45));

    // tail chase with a length-4 snake
    barrier_pos = 8'd200;
    apple_pos   = 8'd46;
    do_reset();
    do_step(2'd1, r1, r2, r3, go1, go2, h3);
    apple_pos = 8'd0;
    do_step(2'd2, r1, r2, r3, go1, go2, h3);
    do_step(2'd3, r1, r2, r3, go1, go2, h3);
    do_step(2'd0, r1, r2, r3, go1, go2, h3);
    chk("tail_go", 101'(game_over), 101'(0));
    chk("tail_head", head_grid, g(45));
    chk("tail_body", body_grid, g(55) | g(56) | g(46));

    // saturation at MAX_LEN
    do_reset();
    for (int i = 0; i < 15; i++) begin
      apple_pos = 8'(cells[i]);
      do_step(dirs[i], r1, r2, r3, go1, go2, h3);
      if (i == 13) begin
        chk("sat14_len", 101'(length), 101'(16));
        chk("sat14_score", 101'(score), 101'(14));
      end
    end
    chk("sat15_rnd", 101'(r2), 101'(1));
    chk("sat15_len", 101'(length), 101'(16));
    chk("sat15_score", 101'(score), 101'(15));
    chk("sat15_head", head_grid, g(82));
    chk("sat15_go", 101'(game_over), 101'(0));

    // step held through CALC/UPDATE/REBUILD moves only once
    apple_pos = 8'd0;
    dir_in    = 2'd3;
    step      = 1'b1;
    repeat (4) @(negedge clk_25M);
    step = 1'b0;
    repeat (6) @(negedge clk_25M);
    chk("drop_head", head_grid, g(81));
    chk("drop_go", 101'(game_over), 101'(0));
    chk("drop_len", 101'(length), 101'(16));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
